// File: rtl/vc_beat_sequencer.sv
// Splits queued line commands into DS_N beat requests, linear or critical-beat-first.
// Commands are bypassed straight into the active slot when the queue is empty.
module vc_beat_sequencer #(
    parameter int DS_N       = 4,
    parameter int PLD_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(DS_N),
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int QW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [PLD_WIDTH-1:0] in_pld,
    input  logic [CW-1:0]        in_start,
    input  logic                 in_wrap,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [PLD_WIDTH-1:0] out_pld,
    output logic [CW-1:0]        out_req_num,
    output logic                 out_first,
    output logic                 out_last,
    output logic [QW-1:0]        q_cnt,
    output logic                 busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state, state_nxt;

    logic [PLD_WIDTH-1:0] mem_pld   [FIFO_DEPTH];
    logic [CW-1:0]        mem_start [FIFO_DEPTH];
    logic                 mem_wrap  [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    logic [PLD_WIDTH-1:0] act_pld;
    logic [CW-1:0]        act_start;
    logic                 act_wrap;
    logic [CW-1:0]        cnt;

    logic in_fire, out_fire, seq_done, q_empty, pop, load_in, push, take;

    assign in_rdy   = (q_cnt < QW'(FIFO_DEPTH));
    assign out_vld  = (state == ISSUE);
    assign in_fire  = in_vld && in_rdy;
    assign out_fire = out_vld && out_rdy;
    assign seq_done = out_fire && out_last;
    assign q_empty  = (q_cnt == '0);

    // A free active slot takes the queue head first; the incoming command only
    // goes straight in when nothing is queued ahead of it.
    assign take    = (state == IDLE) || seq_done;
    assign pop     = take && !q_empty;
    assign load_in = take && q_empty && in_fire;
    assign push    = in_fire && !load_in;

    assign out_pld     = act_pld;
    assign out_req_num = act_wrap ? (act_start + cnt) : cnt;
    assign out_first   = out_vld && (cnt == '0);
    assign out_last    = out_vld && (cnt == CW'(DS_N - 1));
    assign busy        = out_vld || !q_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop || load_in) state_nxt = ISSUE;
            ISSUE:   if (seq_done && !pop && !load_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pld[wr_ptr]   <= in_pld;
            mem_start[wr_ptr] <= in_start;
            mem_wrap[wr_ptr]  <= in_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            cnt       <= '0;
            act_pld   <= '0;
            act_start <= '0;
            act_wrap  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
            if (pop) begin
                act_pld   <= mem_pld[rd_ptr];
                act_start <= mem_start[rd_ptr];
                act_wrap  <= mem_wrap[rd_ptr];
            end else if (load_in) begin
                act_pld   <= in_pld;
                act_start <= in_start;
                act_wrap  <= in_wrap;
            end
            if (pop || load_in) cnt <= '0;
            else if (out_fire)  cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_beat_sequencer.sv
// Bench for vc_beat_sequencer: queue-based command model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_vc_beat_sequencer;

    localparam int DS_N  = 4;
    localparam int PW    = 64;
    localparam int DEPTH = 4;

    logic          clk, rst_n;
    logic          in_vld, in_rdy, in_wrap;
    logic [PW-1:0] in_pld, out_pld;
    logic [1:0]    in_start, out_req_num;
    logic          out_vld, out_rdy, out_first, out_last, busy;
    logic [2:0]    q_cnt;

    int vectors = 0;
    int miscompares = 0;

    vc_beat_sequencer #(.DS_N(DS_N), .PLD_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_pld(in_pld),
        .in_start(in_start), .in_wrap(in_wrap),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_pld(out_pld),
        .out_req_num(out_req_num), .out_first(out_first), .out_last(out_last),
        .q_cnt(q_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pld;
        logic [1:0]    start;
        logic          wrap;
    } cmd_t;

    // Model: every accepted command waits in mq; the active one is m_cur, on beat m_k.
    cmd_t mq[$];
    cmd_t m_cur;
    bit   m_act = 0;
    int   m_k = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            bit fo, fi;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_act = 0;
                m_k = 0;
            end else begin
                fo = m_act && out_rdy;
                fi = in_vld && (mq.size() < DEPTH);
                if (fo) begin
                    if (m_k == DS_N - 1) m_act = 0;
                    else m_k++;
                end
                if (fi) mq.push_back('{in_pld, in_start, in_wrap});
                if (!m_act && mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_act = 1;
                    m_k = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            int exp_req;
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_vld",   out_vld, 0);
                chk("rst_rdy",   in_rdy, 1);
                chk("rst_qcnt",  q_cnt, 0);
                chk("rst_busy",  busy, 0);
                chk("rst_first", out_first, 0);
                chk("rst_last",  out_last, 0);
                chk("rst_req",   out_req_num, 0);
                chk("rst_pld",   out_pld, 0);
            end else begin
                chk("m_vld",   out_vld, m_act);
                chk("m_rdy",   in_rdy, mq.size() < DEPTH);
                chk("m_qcnt",  q_cnt, mq.size());
                chk("m_busy",  busy, m_act || mq.size() != 0);
                chk("m_first", out_first, m_act && m_k == 0);
                chk("m_last",  out_last, m_act && m_k == DS_N - 1);
                if (m_act) begin
                    exp_req = m_cur.wrap ? (m_cur.start + m_k) % DS_N : m_k;
                    chk("m_req", out_req_num, exp_req);
                    chk("m_pld", out_pld, m_cur.pld);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p, input logic [1:0] s, input logic w);
        in_vld = 1'b1;
        in_pld = p;
        in_start = s;
        in_wrap = w;
    endtask

    initial begin
        int exp2[4];
        int pat[4];
        int hs;
        bit acc;
        exp2 = '{2, 3, 0, 1};
        pat  = '{1, 0, 0, 1};

        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        in_pld = '0; in_start = '0; in_wrap = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Linear single command
        out_rdy = 1'b1;
        send(64'hA, 2'd3, 1'b0);
        cyc();
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_vld", out_vld, 1);
            chk("t1_req", out_req_num, i);
            chk("t1_first", out_first, i == 0);
            chk("t1_last", out_last, i == 3);
        end
        @(negedge clk);
        chk("t1_idle", out_vld, 0);
        chk("t1_busy", busy, 0);

        // Wrap order from beat 2
        cyc();
        send(64'hB, 2'd2, 1'b1);
        cyc();
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_req", out_req_num, exp2[i]);
            chk("t2_last", out_last, i == 3);
        end
        @(negedge clk);
        chk("t2_idle", out_vld, 0);

        // Fill the queue while stalled, then drain with a 1,0,0,1 ready pattern
        cyc();
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(64'd100 + 64'(i), 2'(i), i[0]);
            cyc();
        end
        send(64'd105, 2'd1, 1'b1);
        @(negedge clk);
        chk("t3_qcnt", q_cnt, 4);
        chk("t3_rdy", in_rdy, 0);
        chk("t3_pld", out_pld, 100);
        repeat (3) cyc();
        @(negedge clk);
        chk("t3_hold", q_cnt, 4);
        cyc();
        hs = 0;
        for (int n = 0; n < 70; n++) begin
            out_rdy = pat[n % 4][0];
            acc = in_vld && in_rdy;
            if (out_vld && out_rdy) hs++;
            cyc();
            if (acc) in_vld = 1'b0;
        end
        chk("t3_handshakes", hs, 24);
        @(negedge clk);
        chk("t3_busy", busy, 0);

        // Command arriving on the last beat with an empty queue is loaded directly
        cyc();
        out_rdy = 1'b1;
        send(64'hC, 2'd0, 1'b0);
        cyc();
        in_vld = 1'b0;
        repeat (3) cyc();
        send(64'hD, 2'd1, 1'b1);
        cyc();
        in_vld = 1'b0;
        @(negedge clk);
        chk("t4_vld", out_vld, 1);
        chk("t4_pld", out_pld, 64'hD);
        chk("t4_req", out_req_num, 1);
        chk("t4_first", out_first, 1);

        // Mixed traffic pattern, then drain
        cyc();
        for (int i = 0; i < 40; i++) begin
            in_vld = (i % 3 != 0);
            in_pld = 64'h1000 + 64'(i);
            in_start = 2'(i % 4);
            in_wrap = i[0];
            out_rdy = (i % 5 != 1);
            cyc();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (40) cyc();

        // Reset mid-sequence at cnt=2 with two queued commands
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(64'hE0 + 64'(i), 2'd0, 1'b0);
            cyc();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        cyc();
        cyc();
        out_rdy = 1'b0;
        @(negedge clk);
        chk("t5_req", out_req_num, 2);
        chk("t5_qcnt", q_cnt, 2);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", out_vld, 0);
        chk("t5_rst_qcnt", q_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_post_vld", out_vld, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vc_beat_sequencer.md
VC_BEAT_SEQUENCER -- requirements
Module: vc_beat_sequencer

Interface
REQ-001 SHALL have parameter DS_N, default 4: beats per cache line; power of two, at least 2.
REQ-002 SHALL have parameter PLD_WIDTH, default 64: width of the opaque command payload (e.g. packed linefill/evict request).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command queue entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-006 SHALL have port in_vld, input, 1: line command valid.
REQ-007 SHALL have port in_rdy, output, 1: line command accepted when in_vld && in_rdy.
REQ-008 SHALL have port in_pld, input, PLD_WIDTH: command payload.
REQ-009 SHALL have port in_start, input, $clog2(DS_N): critical beat index.
REQ-010 SHALL have port in_wrap, input, 1: 1 = critical-beat-first wrap order, 0 = linear order from beat 0.
REQ-011 SHALL have port out_vld, output, 1: beat valid.
REQ-012 SHALL have port out_rdy, input, 1: beat accepted when out_vld && out_rdy.
REQ-013 SHALL have port out_pld, output, PLD_WIDTH: payload of the command being sequenced.
REQ-014 SHALL have port out_req_num, output, $clog2(DS_N): line beat index of the current beat.
REQ-015 SHALL have port out_first, output, 1: current beat is beat 0 of its command sequence.
REQ-016 SHALL have port out_last, output, 1: current beat is the final beat (sequence count DS_N-1).
REQ-017 SHALL have port q_cnt, output, $clog2(FIFO_DEPTH)+1: number of queued commands, excluding the active one.
REQ-018 SHALL have port busy, output, 1: a command is active or queued.

Function
REQ-019 SHALL queue accepted commands (pld, start, wrap) in FIFO order, depth FIFO_DEPTH.
REQ-020 SHALL drive in_rdy = (q_cnt < FIFO_DEPTH), independent of out_rdy; there is no same-cycle pass-through when full.
REQ-021 SHALL implement FSM states IDLE and ISSUE; out_vld=1 exactly in ISSUE.
REQ-022 IDLE with queue empty SHALL bypass: an accepted command moves directly to the active register, entering ISSUE at the next edge (1-cycle in-to-out latency).
REQ-023 IDLE with queue non-empty (unreachable except after reset deassertion races) SHALL pop the head and enter ISSUE.
REQ-024 On entering ISSUE, the beat counter cnt SHALL be 0.
REQ-025 SHALL output out_req_num = (start + cnt) mod DS_N when wrap=1, otherwise cnt; the addition truncates to $clog2(DS_N) bits.
REQ-026 SHALL drive out_first = (cnt==0) and out_last = (cnt==DS_N-1).
REQ-027 SHALL keep out_pld, out_req_num, out_first and out_last stable while out_vld && !out_rdy.
REQ-028 On a handshake with !out_last, cnt SHALL increment by 1.
REQ-029 On a handshake with out_last and queue non-empty, SHALL load the head and restart with cnt=0 with no bubble cycle.
REQ-030 On a handshake with out_last, queue empty and in handshake in the same cycle, SHALL load the incoming command directly with no bubble.
REQ-031 On a handshake with out_last, queue empty and no input, SHALL return to IDLE.
REQ-032 A simultaneous push and pop SHALL leave q_cnt unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-033 SHALL drive busy = (state==ISSUE) || (q_cnt!=0).

Reset
REQ-034 While rst_n=0, SHALL hold state=IDLE, cnt=0, FIFO pointers=0, q_cnt=0, out_vld=0, busy=0, in_rdy=1, out_first=0, out_last=0, out_req_num=0 and out_pld=0.
REQ-035 Reset asserted mid-sequence SHALL discard the active and queued commands immediately; no beat is emitted after deassertion until a new command is accepted.

Verification
REQ-036 SHALL cover: single command with wrap=0 and out_rdy=1 -> out_vld from the next cycle for 4 cycles, req_num 0,1,2,3; first on beat 0, last on beat 3; then IDLE.
REQ-037 SHALL cover: wrap=1 with start=2 -> req_num 2,3,0,1; last with req_num=1.
REQ-038 SHALL cover: 5 commands pushed back-to-back with out_rdy=0 -> the first becomes active, 4 are queued; in_rdy=0 with q_cnt=4; the 6th is held off until the first pop.
REQ-039 SHALL cover: out_rdy toggling 1,0,0,1,... -> outputs stable during stalls, exactly DS_N handshakes per command, no duplicated or skipped req_num.
REQ-040 SHALL cover: two queued commands -> last beat of A is followed by first beat of B in the very next cycle, with no bubble.
REQ-041 SHALL cover: rst_n pulsed low at cnt=2 with 2 queued commands -> out_vld=0 and q_cnt=0 immediately, and busy=0.
